pmul_job_scheduler: RTL and testbench

PMUL_JOB_SCHEDULER -- requirements
Module: pmul_job_scheduler

---
 rtl/pmul_job_scheduler.sv | 154 +++++++++++++++
 tb/tb_pmul_job_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmul_job_scheduler.sv
// Dispatches point-multiply jobs onto NUM_UNITS external double-and-add engines
// and returns their results through a single registered valid/ready port.
module pmul_job_scheduler #(
  parameter int NUM_UNITS = 4,
  parameter int TAG_W     = 8,
  parameter int P_WIDTH   = 256
) (
  input  logic                                 clk,
  input  logic                                 Reset,
  input  logic                                 job_valid,
  output logic                                 job_ready,
  input  logic [P_WIDTH-1:0]                   job_k,
  input  logic [P_WIDTH-1:0]                   job_Px,
  input  logic [P_WIDTH-1:0]                   job_Py,
  input  logic [TAG_W-1:0]                     job_tag,
  output logic [NUM_UNITS-1:0]                 unit_rst,
  output logic [NUM_UNITS-1:0][P_WIDTH-1:0]    unit_k,
  output logic [NUM_UNITS-1:0][P_WIDTH-1:0]    unit_Px,
  output logic [NUM_UNITS-1:0][P_WIDTH-1:0]    unit_Py,
  input  logic [NUM_UNITS-1:0]                 unit_done,
  input  logic [NUM_UNITS-1:0][P_WIDTH-1:0]    unit_Rx,
  input  logic [NUM_UNITS-1:0][P_WIDTH-1:0]    unit_Ry,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [P_WIDTH-1:0]                   res_Rx,
  output logic [P_WIDTH-1:0]                   res_Ry,
  output logic [TAG_W-1:0]                     res_tag,
  output logic [$clog2(NUM_UNITS)-1:0]         res_unit,
  output logic [$clog2(NUM_UNITS):0]           in_flight,
  output logic                                 idle
);
  localparam int UW = $clog2(NUM_UNITS);
  localparam logic [UW:0] FLT_ONE = (UW+1)'(1);

  typedef enum logic [2:0] {IDLE, START, GUARD, RUN, DONE} ustate_t;

  ustate_t                st     [NUM_UNITS];
  ustate_t                st_nxt [NUM_UNITS];
  logic [TAG_W-1:0]       tag_q  [NUM_UNITS];
  logic [UW-1:0]          alloc_ptr, out_ptr;
  logic [UW-1:0]          alloc_idx, cap_idx;
  logic                   alloc_found, cap_found;
  logic                   accept, cap;
  logic                   rst_hold;
  logic [NUM_UNITS-1:0]   idle_vec, done_vec;

  function automatic logic [UW:0] rr_pick(input logic [NUM_UNITS-1:0] req,
                                          input logic [UW-1:0] ptr);
    logic          found;
    logic [UW-1:0] sel;
    logic [UW-1:0] jj;
    int            j;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_UNITS) j = j - NUM_UNITS;
      jj = UW'(j);
      if (!found && req[jj]) begin
        found = 1'b1;
        sel   = jj;
      end
    end
    return {found, sel};
  endfunction

  function automatic logic [UW-1:0] wrap_inc(input logic [UW-1:0] idx);
    return (idx == UW'(NUM_UNITS-1)) ? '0 : idx + UW'(1);
  endfunction

  always_comb begin
    idle_vec  = '0;
    done_vec  = '0;
    in_flight = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      idle_vec[i] = (st[i] == IDLE);
      done_vec[i] = (st[i] == DONE);
      unit_rst[i] = rst_hold | (st[i] == START);
      if (st[i] != IDLE) in_flight = in_flight + FLT_ONE;
    end
    {alloc_found, alloc_idx} = rr_pick(idle_vec, alloc_ptr);
    {cap_found, cap_idx}     = rr_pick(done_vec, out_ptr);
    // rst_hold keeps jobs out while the engines are still being held in reset
    job_ready = alloc_found && !rst_hold;
    accept    = job_valid && job_ready;
    cap       = !res_valid || res_ready;
    idle      = (in_flight == '0) && !res_valid;
  end

  // Unit FSMs; Done is only honoured in RUN so a stale Done never completes a new job
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      st_nxt[i] = st[i];
      unique case (st[i])
        IDLE:    if (accept && alloc_idx == UW'(i)) st_nxt[i] = START;
        START:   st_nxt[i] = GUARD;
        GUARD:   st_nxt[i] = RUN;
        RUN:     if (unit_done[i]) st_nxt[i] = DONE;
        DONE:    if (cap && cap_found && cap_idx == UW'(i)) st_nxt[i] = IDLE;
        default: st_nxt[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_UNITS; i++) st[i] <= IDLE;
      rst_hold <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) st[i] <= st_nxt[i];
      rst_hold <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        unit_k[i]  <= '0;
        unit_Px[i] <= '0;
        unit_Py[i] <= '0;
        tag_q[i]   <= '0;
      end
      alloc_ptr <= '0;
    end else if (accept) begin
      unit_k[alloc_idx]  <= job_k;
      unit_Px[alloc_idx] <= job_Px;
      unit_Py[alloc_idx] <= job_Py;
      tag_q[alloc_idx]   <= job_tag;
      alloc_ptr          <= wrap_inc(alloc_idx);
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      res_valid <= 1'b0;
      res_Rx    <= '0;
      res_Ry    <= '0;
      res_tag   <= '0;
      res_unit  <= '0;
      out_ptr   <= '0;
    end else if (cap) begin
      if (cap_found) begin
        res_valid <= 1'b1;
        res_Rx    <= unit_Rx[cap_idx];
        res_Ry    <= unit_Ry[cap_idx];
        res_tag   <= tag_q[cap_idx];
        res_unit  <= cap_idx;
        out_ptr   <= wrap_inc(cap_idx);
      end else begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pmul_job_scheduler.sv
// Directed bench for pmul_job_scheduler with a latency-programmable engine model.
module tb_pmul_job_scheduler;
  localparam int N  = 4;
  localparam int TW = 8;
  localparam int PW = 256;
  localparam logic [PW-1:0] GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [PW-1:0] GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

  logic clk = 1'b0;
  logic Reset;
  logic job_valid, job_ready;
  logic [PW-1:0] job_k, job_Px, job_Py;
  logic [TW-1:0] job_tag;
  logic [N-1:0] unit_rst, unit_done;
  logic [N-1:0][PW-1:0] unit_k, unit_Px, unit_Py, unit_Rx, unit_Ry;
  logic res_valid, res_ready;
  logic [PW-1:0] res_Rx, res_Ry;
  logic [TW-1:0] res_tag;
  logic [1:0] res_unit;
  logic [2:0] in_flight;
  logic idle;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat [N];
  int cnt [N];
  logic [N-1:0] mdl_done, frc_en, frc_val;

  logic [TW-1:0] r_tag [$];
  logic [1:0]    r_unit [$];
  logic [PW-1:0] r_rx [$];
  logic [PW-1:0] r_ry [$];
  int            r_c [$];
  int            acc_c [$];
  int            st_unit [$];

  pmul_job_scheduler dut (
    .clk(clk), .Reset(Reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_k(job_k), .job_Px(job_Px),
    .job_Py(job_Py), .job_tag(job_tag),
    .unit_rst(unit_rst), .unit_k(unit_k), .unit_Px(unit_Px), .unit_Py(unit_Py),
    .unit_done(unit_done), .unit_Rx(unit_Rx), .unit_Ry(unit_Ry),
    .res_valid(res_valid), .res_ready(res_ready), .res_Rx(res_Rx), .res_Ry(res_Ry),
    .res_tag(res_tag), .res_unit(res_unit), .in_flight(in_flight), .idle(idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: Done rises lat cycles after the reset/start cycle and stays up until the next start
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (unit_rst[i]) begin
        cnt[i]      <= lat[i] - 1;
        mdl_done[i] <= 1'b0;
      end else if (cnt[i] == 1) begin
        cnt[i]      <= 0;
        mdl_done[i] <= 1'b1;
      end else if (cnt[i] > 1) begin
        cnt[i] <= cnt[i] - 1;
      end
    end
  end

  assign unit_done = (frc_en & frc_val) | (~frc_en & mdl_done);
  for (genvar g = 0; g < N; g++) begin : g_res
    assign unit_Rx[g] = unit_Px[g] + unit_k[g] - PW'(1);
    assign unit_Ry[g] = unit_Py[g] + unit_k[g] - PW'(1);
  end

  always begin
    @(negedge clk);
    #2;
    if (res_valid && res_ready) begin
      r_tag.push_back(res_tag);
      r_unit.push_back(res_unit);
      r_rx.push_back(res_Rx);
      r_ry.push_back(res_Ry);
      r_c.push_back(cyc);
    end
    if (job_valid && job_ready) acc_c.push_back(cyc);
    if ($onehot(unit_rst)) begin
      for (int i = 0; i < N; i++) if (unit_rst[i]) st_unit.push_back(i);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    job_valid = 1'b0;
    res_ready = 1'b0;
    frc_en    = '0;
    frc_val   = '0;
    Reset     = 1'b0;
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    repeat (2) @(negedge clk);
    r_tag.delete(); r_unit.delete(); r_rx.delete(); r_ry.delete(); r_c.delete();
    acc_c.delete(); st_unit.delete();
  endtask

  task automatic wait_results(input int want, input int budget, input string tag);
    int n;
    n = 0;
    while (r_tag.size() < want && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, PW'(r_tag.size()), PW'(want));
  endtask

  initial begin
    int n;
    int seen;
    logic [PW-1:0] snap_rx, snap_ry;
    logic [TW+1:0] snap_id;

    Reset = 1'b1; job_valid = 1'b0; job_k = '0; job_Px = '0; job_Py = '0; job_tag = '0;
    res_ready = 1'b0; frc_en = '0; frc_val = '0;
    for (int i = 0; i < N; i++) lat[i] = 10;
    #3 Reset = 1'b0;
    #1;
    chk("rst_job_ready", PW'(job_ready), PW'(0));
    chk("rst_res_valid", PW'(res_valid), PW'(0));
    chk("rst_in_flight", PW'(in_flight), PW'(0));
    chk("rst_idle", PW'(idle), PW'(1));
    chk("rst_unit_rst", PW'(unit_rst), PW'(4'hF));
    chk("rst_res_rx", res_Rx, PW'(0));
    repeat (2) @(negedge clk);
    chk("rst_held_unit_rst", PW'(unit_rst), PW'(4'hF));
    Reset = 1'b1;
    #1;
    chk("rel_unit_rst", PW'(unit_rst), PW'(4'hF));
    chk("rel_job_ready", PW'(job_ready), PW'(0));
    @(negedge clk);
    chk("post_rel_unit_rst", PW'(unit_rst), PW'(0));
    chk("post_rel_job_ready", PW'(job_ready), PW'(1));

    // single job, Done latency 10
    job_valid = 1'b1; job_k = PW'(1); job_Px = GX; job_Py = GY; job_tag = 8'h05; res_ready = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    chk("t1_start_rst", PW'(unit_rst), PW'(4'b0001));
    chk("t1_in_flight", PW'(in_flight), PW'(1));
    chk("t1_operand_px", unit_Px[0], GX);
    @(negedge clk);
    chk("t1_rst_one_cycle", PW'(unit_rst), PW'(0));
    repeat (10) @(negedge clk);
    chk("t1_no_early_res", PW'(res_valid), PW'(0));
    chk("t1_in_flight_run", PW'(in_flight), PW'(1));
    chk("t1_operand_k_stable", unit_k[0], PW'(1));
    @(negedge clk);
    chk("t1_res_valid", PW'(res_valid), PW'(1));
    chk("t1_res_rx", res_Rx, GX);
    chk("t1_res_ry", res_Ry, GY);
    chk("t1_res_tag", PW'(res_tag), PW'(8'h05));
    chk("t1_res_unit", PW'(res_unit), PW'(0));
    chk("t1_in_flight_done", PW'(in_flight), PW'(0));
    chk("t1_not_idle", PW'(idle), PW'(0));
    @(negedge clk);
    chk("t1_res_drop", PW'(res_valid), PW'(0));
    chk("t1_idle", PW'(idle), PW'(1));

    // five back-to-back jobs
    do_reset();
    res_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      job_valid = 1'b1; job_tag = TW'(j); job_k = PW'(j); job_Px = PW'(16*j); job_Py = PW'(16*j+1);
      n = 0;
      while (!job_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("t2_accept_job%0d", j), PW'(n < 40), PW'(1));
      @(negedge clk);
      if (j == 4) chk("t2_full_job_ready", PW'(job_ready), PW'(0));
    end
    job_valid = 1'b0;
    wait_results(5, 60, "t2_result_count");
    for (int j = 0; j < 5 && j < r_tag.size(); j++) begin
      chk($sformatf("t2_tag%0d", j), PW'(r_tag[j]), PW'(j+1));
      chk($sformatf("t2_unit%0d", j), PW'(r_unit[j]), PW'(j % 4));
      chk($sformatf("t2_rx%0d", j), r_rx[j], PW'(17*(j+1)-1));
      chk($sformatf("t2_ry%0d", j), r_ry[j], PW'(17*(j+1)));
    end
    for (int j = 0; j < 5 && j < st_unit.size(); j++)
      chk($sformatf("t2_start_unit%0d", j), PW'(st_unit[j]), PW'(j % 4));
    if (acc_c.size() == 5 && r_c.size() >= 1) begin
      chk("t2_gap_12", PW'(acc_c[1] - acc_c[0]), PW'(1));
      chk("t2_gap_14", PW'(acc_c[3] - acc_c[0]), PW'(3));
      chk("t2_gap_15", PW'(acc_c[4] - acc_c[0]), PW'(13));
      chk("t2_job5_after_capture", PW'(acc_c[4]), PW'(r_c[0]));
    end else begin
      chk("t2_accept_count", PW'(acc_c.size()), PW'(5));
    end

    // units 1 and 2 finish together
    do_reset();
    lat[0] = 40; lat[1] = 11; lat[2] = 10; lat[3] = 10;
    res_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      job_valid = 1'b1; job_tag = TW'(8'hA0 + j); job_k = PW'(1); job_Px = PW'(100+j); job_Py = PW'(200+j);
      @(negedge clk);
    end
    job_valid = 1'b0;
    wait_results(3, 80, "t3_result_count");
    if (r_tag.size() >= 3 && acc_c.size() >= 2) begin
      chk("t3_first_unit", PW'(r_unit[0]), PW'(1));
      chk("t3_first_tag", PW'(r_tag[0]), PW'(8'hA1));
      chk("t3_second_unit", PW'(r_unit[1]), PW'(2));
      chk("t3_second_tag", PW'(r_tag[1]), PW'(8'hA2));
      chk("t3_consecutive", PW'(r_c[1] - r_c[0]), PW'(1));
      chk("t3_latency", PW'(r_c[0] - acc_c[1]), PW'(14));
      chk("t3_third_unit", PW'(r_unit[2]), PW'(0));
      chk("t3_third_rx", r_rx[2], PW'(100));
    end

    // back-pressure with every unit occupied
    do_reset();
    for (int i = 0; i < N; i++) lat[i] = 10;
    for (int j = 0; j < 4; j++) begin
      job_valid = 1'b1; job_tag = TW'(8'h11 + j); job_k = PW'(2); job_Px = PW'(1000+j); job_Py = PW'(2000+j);
      @(negedge clk);
    end
    lat[0] = 60;
    job_tag = 8'h15; job_k = PW'(3); job_Px = PW'(5000); job_Py = PW'(6000);
    n = 0;
    while (!job_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t4_accept_job5", PW'(n < 40), PW'(1));
    @(negedge clk);
    job_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_res_valid", PW'(res_valid), PW'(1));
    chk("t4_res_tag", PW'(res_tag), PW'(8'h11));
    chk("t4_res_rx", res_Rx, PW'(1001));
    snap_rx = res_Rx; snap_ry = res_Ry; snap_id = {res_tag, res_unit};
    repeat (20) begin
      @(negedge clk);
      chk("t4_hold_valid", PW'(res_valid), PW'(1));
      chk("t4_hold_id", PW'({res_tag, res_unit}), PW'(snap_id));
      chk("t4_hold_rx", res_Rx, snap_rx);
      chk("t4_hold_ry", res_Ry, snap_ry);
      chk("t4_hold_job_ready", PW'(job_ready), PW'(0));
    end
    res_ready = 1'b1;
    wait_results(4, 10, "t4_drain_count");
    for (int j = 0; j < 4 && j < r_tag.size(); j++) begin
      chk($sformatf("t4_drain_tag%0d", j), PW'(r_tag[j]), PW'(8'h11 + j));
      chk($sformatf("t4_drain_unit%0d", j), PW'(r_unit[j]), PW'(j));
      chk($sformatf("t4_drain_ry%0d", j), r_ry[j], PW'(2001 + j));
      chk($sformatf("t4_drain_cycle%0d", j), PW'(r_c[j] - r_c[0]), PW'(j));
    end
    chk("t4_after_drain_valid", PW'(res_valid), PW'(0));
    chk("t4_after_drain_in_flight", PW'(in_flight), PW'(1));

    // stale Done held over from a previous job
    do_reset();
    res_ready = 1'b1;
    frc_en = 4'b0001; frc_val = 4'b0001;
    job_valid = 1'b1; job_tag = 8'h29; job_k = PW'(1); job_Px = PW'(77); job_Py = PW'(88);
    @(negedge clk);
    job_valid = 1'b0;
    chk("t5_start_rst", PW'(unit_rst), PW'(4'b0001));
    @(negedge clk);
    chk("t5_guard_no_res", PW'(res_valid), PW'(0));
    @(negedge clk);
    frc_val = 4'b0000;
    for (int c = 3; c <= 9; c++) begin
      chk($sformatf("t5_no_res_c%0d", c), PW'(res_valid), PW'(0));
      if (c == 8) frc_val = 4'b0001;
      @(negedge clk);
    end
    chk("t5_res_valid", PW'(res_valid), PW'(1));
    chk("t5_res_tag", PW'(res_tag), PW'(8'h29));
    chk("t5_res_rx", res_Rx, PW'(77));
    frc_en = 4'b0000;

    // reset with jobs in flight and a result pending
    do_reset();
    lat[0] = 4; lat[1] = 30; lat[2] = 30; lat[3] = 30;
    for (int j = 0; j < 4; j++) begin
      job_valid = 1'b1; job_tag = TW'(8'h60 + j); job_k = PW'(1); job_Px = PW'(j+1); job_Py = PW'(j+9);
      @(negedge clk);
    end
    job_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_pre_res_valid", PW'(res_valid), PW'(1));
    chk("t6_pre_in_flight", PW'(in_flight), PW'(3));
    Reset = 1'b0;
    #1;
    chk("t6_res_valid", PW'(res_valid), PW'(0));
    chk("t6_res_tag", PW'(res_tag), PW'(0));
    chk("t6_res_rx", res_Rx, PW'(0));
    chk("t6_in_flight", PW'(in_flight), PW'(0));
    chk("t6_idle", PW'(idle), PW'(1));
    chk("t6_job_ready", PW'(job_ready), PW'(0));
    chk("t6_unit_rst", PW'(unit_rst), PW'(4'hF));
    chk("t6_unit_k1", unit_k[1], PW'(0));
    chk("t6_unit_px2", unit_Px[2], PW'(0));
    repeat (3) @(negedge clk);
    chk("t6_held_unit_rst", PW'(unit_rst), PW'(4'hF));
    Reset = 1'b1;
    #1;
    chk("t6_rel_unit_rst", PW'(unit_rst), PW'(4'hF));
    @(negedge clk);
    chk("t6_post_rel_unit_rst", PW'(unit_rst), PW'(0));
    chk("t6_post_rel_job_ready", PW'(job_ready), PW'(1));
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    chk("t6_no_res_after_reset", PW'(seen), PW'(0));
    chk("t6_in_flight_after", PW'(in_flight), PW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
